// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// slave is the adder side, master is the producer/consumer side.
interface cla_seq_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_seq_adder.sv
// Wide add/subtract built from one 4-bit carry-lookahead adder stepped
// LSB-first over the operands, one nibble per clock.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_seq_adder_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES + 1);
    localparam logic [KW-1:0] KLAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          ovf_q;
    logic [KW-1:0] k_q;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_c;
    logic          last;

    assign last = (k_q == KLAST);

    // Nibble select as a constant-index compare mux keeps every slice static.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (k_q == KW'(i)) begin
                nib_a = opa_q[4*i +: 4];
                nib_b = opb_q[4*i +: 4];
            end
        end
    end

    cla u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        k_q     <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NIBBLES; i++) begin
                        if (k_q == KW'(i)) begin
                            sum_q[4*i +: 4] <= nib_s;
                        end
                    end
                    carry_q <= nib_c;
                    k_q     <= k_q + KW'(1);
                    // opb_q is already inverted for subtraction, so one rule covers both ops.
                    if (last) begin
                        cout_q <= nib_c;
                        ovf_q  <= (opa_q[W-1] == opb_q[W-1]) && (nib_s[3] != opa_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
